// File: rtl/waveform_recorder_pkg.sv
// Shared types for the waveform recorder: FSM encodings
// and the RAM-word split of a stored sample.
package waveform_recorder_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DO_WAIT,
    S_WAIT_ON_ADC,
    S_FLUSH,
    S_DONE
  } rec_state_t;

  typedef enum logic [2:0] {
    F_IDLE,
    F_READ,
    F_LOAD,
    F_LO,
    F_GAP,
    F_HI
  } flush_state_t;

  localparam int SAMPLE_WID = 24;
  localparam int HALF_WID   = 16;

  function automatic logic [HALF_WID-1:0] word_lo(
    input logic [SAMPLE_WID-1:0] w
  );
    return w[HALF_WID-1:0];
  endfunction

  // Upper bits travel as a sign-extended RAM word.
  function automatic logic [HALF_WID-1:0] word_hi(
    input logic [SAMPLE_WID-1:0] w
  );
    return HALF_WID'($signed(w[SAMPLE_WID-1:HALF_WID]));
  endfunction

endpackage

// File: rtl/waveform_recorder_bram_writer.sv
// Sample buffer plus DMA flush engine: streams every
// buffered sample to RAM as a low/high word pair.
module waveform_recorder_bram_writer
  import waveform_recorder_pkg::*;
#(
  parameter int WORD_WID      = 24,
  parameter int WORD_AMNT_WID = 11,
  parameter int WORD_AMNT     = 2047,
  parameter int RAM_WID       = 32,
  parameter int RAM_WORD_WID  = 16,
  parameter int RAM_WORD_INCR = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WORD_AMNT_WID-1:0] wr_idx,
  input  logic [WORD_WID-1:0]      wr_data,
  input  logic                     flush_start,
  input  logic [RAM_WID-1:0]       start_addr,
  output logic                     flush_finished,
  output logic [RAM_WID-1:0]       ram_dma_addr,
  output logic [RAM_WORD_WID-1:0]  ram_word,
  output logic                     ram_write,
  input  logic                     ram_valid
);

  localparam logic [WORD_AMNT_WID-1:0] LAST =
    WORD_AMNT_WID'(WORD_AMNT);
  localparam logic [RAM_WID-1:0] INCR =
    RAM_WID'(RAM_WORD_INCR);

  logic [WORD_WID-1:0] mem [0:WORD_AMNT];
  logic [WORD_WID-1:0] rd_q;

  flush_state_t               fstate, fstate_d;
  logic [WORD_AMNT_WID-1:0]   rd_idx, rd_idx_d;
  logic [RAM_WID-1:0]         addr_d;
  logic [RAM_WORD_WID-1:0]    word_d;
  logic                       write_d;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
    rd_q <= mem[rd_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fstate       <= F_IDLE;
      rd_idx       <= '0;
      ram_dma_addr <= '0;
      ram_word     <= '0;
      ram_write    <= 1'b0;
    end else begin
      fstate       <= fstate_d;
      rd_idx       <= rd_idx_d;
      ram_dma_addr <= addr_d;
      ram_word     <= word_d;
      ram_write    <= write_d;
    end
  end

  // F_READ covers the one-cycle BRAM read latency.
  always_comb begin
    fstate_d       = fstate;
    rd_idx_d       = rd_idx;
    addr_d         = ram_dma_addr;
    word_d         = ram_word;
    write_d        = ram_write;
    flush_finished = 1'b0;
    unique case (fstate)
      F_IDLE: begin
        if (flush_start) begin
          rd_idx_d = '0;
          addr_d   = start_addr;
          fstate_d = F_READ;
        end
      end
      F_READ: fstate_d = F_LOAD;
      F_LOAD: begin
        word_d   = word_lo(rd_q);
        write_d  = 1'b1;
        fstate_d = F_LO;
      end
      F_LO: begin
        if (ram_valid) begin
          write_d  = 1'b0;
          addr_d   = ram_dma_addr + INCR;
          fstate_d = F_GAP;
        end
      end
      F_GAP: begin
        word_d   = word_hi(rd_q);
        write_d  = 1'b1;
        fstate_d = F_HI;
      end
      F_HI: begin
        if (ram_valid) begin
          write_d = 1'b0;
          addr_d  = ram_dma_addr + INCR;
          if (rd_idx == LAST) begin
            flush_finished = 1'b1;
            fstate_d       = F_IDLE;
          end else begin
            rd_idx_d = rd_idx + 1'b1;
            fstate_d = F_READ;
          end
        end
      end
      default: fstate_d = F_IDLE;
    endcase
  end

endmodule

// File: rtl/waveform_recorder.sv
// ADC capture: paced sampling into a buffer, then a
// DMA flush of the whole buffer to main RAM.
module waveform_recorder
  import waveform_recorder_pkg::*;
#(
  parameter int ADC_WID       = 24,
  parameter int TIMER_WID     = 32,
  parameter int WORD_WID      = 24,
  parameter int WORD_AMNT_WID = 11,
  parameter int WORD_AMNT     = 2047,
  parameter int RAM_WID       = 32,
  parameter int RAM_WORD_WID  = 16,
  parameter int RAM_WORD_INCR = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    arm,
  input  logic [TIMER_WID-1:0]    time_to_wait,
  input  logic [RAM_WID-1:0]      start_addr,
  output logic                    stopped,
  output logic                    finished,
  output logic                    adc_arm,
  input  logic                    adc_finished,
  input  logic [ADC_WID-1:0]      measurement,
  output logic [RAM_WID-1:0]      ram_dma_addr,
  output logic [RAM_WORD_WID-1:0] ram_word,
  output logic                    ram_write,
  input  logic                    ram_valid
);

  localparam logic [WORD_AMNT_WID-1:0] LAST =
    WORD_AMNT_WID'(WORD_AMNT);

  rec_state_t               state, state_d;
  logic [TIMER_WID-1:0]     timer, timer_d;
  logic [WORD_AMNT_WID-1:0] idx, idx_d;
  logic [RAM_WID-1:0]       start_q, start_d;
  logic                     adc_arm_d;
  logic                     stopped_d;
  logic                     finished_d;
  logic                     wr_en;
  logic                     flush_start;
  logic                     flush_finished;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      timer    <= '0;
      idx      <= '0;
      start_q  <= '0;
      adc_arm  <= 1'b0;
      stopped  <= 1'b1;
      finished <= 1'b0;
    end else begin
      state    <= state_d;
      timer    <= timer_d;
      idx      <= idx_d;
      start_q  <= start_d;
      adc_arm  <= adc_arm_d;
      stopped  <= stopped_d;
      finished <= finished_d;
    end
  end

  always_comb begin
    state_d     = state;
    timer_d     = timer;
    idx_d       = idx;
    start_d     = start_q;
    adc_arm_d   = adc_arm;
    stopped_d   = stopped;
    finished_d  = finished;
    wr_en       = 1'b0;
    flush_start = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (arm) begin
          start_d   = start_addr;
          timer_d   = time_to_wait;
          idx_d     = '0;
          stopped_d = 1'b0;
          state_d   = S_DO_WAIT;
        end
      end
      S_DO_WAIT: begin
        if (!arm) begin
          stopped_d = 1'b1;
          state_d   = S_IDLE;
        end else if (timer == '0) begin
          adc_arm_d = 1'b1;
          state_d   = S_WAIT_ON_ADC;
        end else begin
          timer_d = timer - 1'b1;
        end
      end
      // An open conversion is always completed, even on abort.
      S_WAIT_ON_ADC: begin
        if (adc_finished) begin
          adc_arm_d = 1'b0;
          wr_en     = 1'b1;
          if (!arm) begin
            stopped_d = 1'b1;
            state_d   = S_IDLE;
          end else if (idx == LAST) begin
            flush_start = 1'b1;
            state_d     = S_FLUSH;
          end else begin
            idx_d   = idx + 1'b1;
            timer_d = time_to_wait;
            state_d = S_DO_WAIT;
          end
        end
      end
      S_FLUSH: begin
        if (flush_finished) begin
          finished_d = 1'b1;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        if (!arm) begin
          finished_d = 1'b0;
          stopped_d  = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  waveform_recorder_bram_writer #(
    .WORD_WID      (WORD_WID),
    .WORD_AMNT_WID (WORD_AMNT_WID),
    .WORD_AMNT     (WORD_AMNT),
    .RAM_WID       (RAM_WID),
    .RAM_WORD_WID  (RAM_WORD_WID),
    .RAM_WORD_INCR (RAM_WORD_INCR)
  ) u_writer (
    .clk            (clk),
    .rst            (rst),
    .wr_en          (wr_en),
    .wr_idx         (idx),
    .wr_data        (WORD_WID'(measurement)),
    .flush_start    (flush_start),
    .start_addr     (start_q),
    .flush_finished (flush_finished),
    .ram_dma_addr   (ram_dma_addr),
    .ram_word       (ram_word),
    .ram_write      (ram_write),
    .ram_valid      (ram_valid)
  );

endmodule

// File: tb/tb_waveform_recorder.sv
// Bench for waveform_recorder: random ADC/RAM responders
// and a sample-list model of the expected RAM image.
module tb_waveform_recorder;

  localparam int WA = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arm = 1'b0;
  logic [31:0] time_to_wait = '0;
  logic [31:0] start_addr = '0;
  logic        stopped;
  logic        finished;
  logic        adc_arm;
  logic        adc_finished = 1'b0;
  logic [23:0] measurement = '0;
  logic [31:0] ram_dma_addr;
  logic [15:0] ram_word;
  logic        ram_write;
  logic        ram_valid = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  int adc_lo = 0, adc_hi = 2;
  int ram_lo = 0, ram_hi = 2;
  int req_cnt = 0;
  int fix_base = 0, fix_n = 0;
  logic [23:0] fix_vals [4];

  logic [23:0] cap_q [$];
  logic [31:0] wa_q [$];
  logic [15:0] wd_q [$];
  int cap_base, wr_base, req_base;

  waveform_recorder #(.WORD_AMNT(WA)) dut (
    .clk          (clk),
    .rst          (rst),
    .arm          (arm),
    .time_to_wait (time_to_wait),
    .start_addr   (start_addr),
    .stopped      (stopped),
    .finished     (finished),
    .adc_arm      (adc_arm),
    .adc_finished (adc_finished),
    .measurement  (measurement),
    .ram_dma_addr (ram_dma_addr),
    .ram_word     (ram_word),
    .ram_write    (ram_write),
    .ram_valid    (ram_valid)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  // ADC: answers each request after a random delay
  initial begin
    int cnt, k;
    logic busy;
    logic [23:0] v;
    cnt = 0; busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || adc_finished) begin
        adc_finished = 1'b0;
        busy = 1'b0;
      end else if (adc_arm) begin
        if (!busy) begin
          busy = 1'b1;
          cnt = $urandom_range(adc_lo, adc_hi);
        end
        if (cnt == 0) begin
          k = cap_q.size() - fix_base;
          if (k < fix_n) v = fix_vals[k];
          else v = 24'($urandom);
          measurement = v;
          adc_finished = 1'b1;
          cap_q.push_back(v);
        end else cnt--;
      end
    end
  end

  // RAM: delayed accept, checks hold-stable and low gap
  initial begin
    int rc;
    logic seen;
    logic [31:0] ra;
    logic [15:0] rw;
    rc = 0; seen = 1'b0; ra = '0; rw = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ram_valid = 1'b0;
        seen = 1'b0;
      end else if (ram_valid) begin
        ram_valid = 1'b0;
        check("wr_gap", 32'(ram_write), 32'd0);
      end else if (ram_write) begin
        if (!seen) begin
          seen = 1'b1;
          ra = ram_dma_addr;
          rw = ram_word;
          rc = $urandom_range(ram_lo, ram_hi);
          req_cnt++;
        end else begin
          check("addr_stable", ram_dma_addr, ra);
          check("data_stable", 32'(ram_word), 32'(rw));
        end
        if (rc == 0) begin
          ram_valid = 1'b1;
          seen = 1'b0;
          wa_q.push_back(ra);
          wd_q.push_back(rw);
        end else rc--;
      end
    end
  end

  // Idle time before each conversion must be wait+1 cycles
  initial begin
    int low;
    logic prev;
    low = 0; prev = 1'b0;
    forever begin
      @(negedge clk);
      if (stopped) low = 0;
      else if (!adc_arm) low++;
      else if (!prev) begin
        check("arm_gap", 32'(low), time_to_wait + 32'd1);
        low = 0;
      end
      prev = adc_arm;
    end
  end

  task automatic snap;
    cap_base = cap_q.size();
    wr_base  = wa_q.size();
    req_base = req_cnt;
  endtask

  task automatic run_full(input logic [31:0] w,
                          input logic [31:0] sa);
    logic ok;
    logic [23:0] s;
    logic [31:0] ea;
    logic [15:0] ed;
    int nc, nw;
    time_to_wait = w;
    start_addr = sa;
    snap();
    arm = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      tick();
      if (finished) begin
        ok = 1'b1;
        break;
      end
    end
    check("finish", 32'(ok), 32'd1);
    check("stopped_run", 32'(stopped), 32'd0);
    nc = cap_q.size() - cap_base;
    nw = wa_q.size() - wr_base;
    check("ncap", 32'(nc), 32'(WA + 1));
    check("nwr", 32'(nw), 32'(2 * (WA + 1)));
    for (int i = 0; i < nw && i / 2 < nc; i++) begin
      s  = cap_q[cap_base + i / 2];
      ea = sa + 32'(i) * 32'd2;
      ed = (i % 2 == 0) ? s[15:0] : {{8{s[23]}}, s[23:16]};
      check("wr_addr", wa_q[wr_base + i], ea);
      check("wr_data", 32'(wd_q[wr_base + i]), 32'(ed));
    end
    tick();
    check("fin_hold", 32'(finished), 32'd1);
    arm = 1'b0;
    tick();
    check("fin_clr", 32'(finished), 32'd0);
    check("stop_set", 32'(stopped), 32'd1);
  endtask

  initial begin
    logic ok;
    rst = 1'b1;
    tick();
    tick();
    check("rst_stopped", 32'(stopped), 32'd1);
    check("rst_finished", 32'(finished), 32'd0);
    check("rst_adc_arm", 32'(adc_arm), 32'd0);
    check("rst_write", 32'(ram_write), 32'd0);
    check("rst_addr", ram_dma_addr, 32'd0);
    check("rst_word", 32'(ram_word), 32'd0);
    rst = 1'b0;
    tick();

    // Directed sample set with known RAM image
    fix_vals = '{24'h123456, 24'h000001,
                 24'h000002, 24'hFFFFFE};
    fix_base = cap_q.size();
    fix_n = 4;
    run_full(32'd2, 32'h1000);
    fix_n = 0;
    if (wa_q.size() >= wr_base + 8) begin
      check("t1_w1", 32'(wd_q[wr_base + 1]), 32'h0012);
      check("t1_a6", wa_q[wr_base + 6], 32'h100C);
      check("t1_w6", 32'(wd_q[wr_base + 6]), 32'hFFFE);
      check("t1_a7", wa_q[wr_base + 7], 32'h100E);
      check("t1_w7", 32'(wd_q[wr_base + 7]), 32'hFFFF);
    end

    // Back-to-back conversions
    adc_hi = 0;
    run_full(32'd0, 32'h4000);
    adc_hi = 2;

    // Abort while waiting between samples
    time_to_wait = 32'd5;
    start_addr = 32'h3000;
    snap();
    arm = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (cap_q.size() - cap_base >= 2) begin
        ok = 1'b1;
        break;
      end
    end
    check("t3_two", 32'(ok), 32'd1);
    tick();
    arm = 1'b0;
    tick();
    check("t3_stopped", 32'(stopped), 32'd1);
    check("t3_adc", 32'(adc_arm), 32'd0);
    repeat (6) tick();
    check("t3_nowr", 32'(req_cnt - req_base), 32'd0);
    check("t3_ncap", 32'(cap_q.size() - cap_base), 32'd2);

    // Abort during a conversion
    adc_lo = 6;
    adc_hi = 6;
    time_to_wait = 32'd1;
    snap();
    arm = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (adc_arm) begin
        ok = 1'b1;
        break;
      end
    end
    check("t4_arm", 32'(ok), 32'd1);
    arm = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      check("t4_hold", 32'(adc_arm), 32'd1);
      if (adc_finished) begin
        ok = 1'b1;
        break;
      end
    end
    check("t4_done", 32'(ok), 32'd1);
    tick();
    check("t4_adc", 32'(adc_arm), 32'd0);
    check("t4_stopped", 32'(stopped), 32'd1);
    check("t4_nowr", 32'(req_cnt - req_base), 32'd0);
    adc_lo = 0;
    adc_hi = 2;

    // Slow RAM accept
    ram_lo = 5;
    ram_hi = 5;
    run_full(32'd1, 32'h5000);

    // Reset in the middle of the flush
    ram_lo = 3;
    ram_hi = 3;
    time_to_wait = 32'd1;
    start_addr = 32'h2000;
    snap();
    arm = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (wa_q.size() - wr_base >= 3) begin
        ok = 1'b1;
        break;
      end
    end
    check("t6_mid", 32'(ok), 32'd1);
    rst = 1'b1;
    #1;
    check("t6_stopped", 32'(stopped), 32'd1);
    check("t6_finished", 32'(finished), 32'd0);
    check("t6_adc", 32'(adc_arm), 32'd0);
    check("t6_write", 32'(ram_write), 32'd0);
    check("t6_addr", ram_dma_addr, 32'd0);
    check("t6_word", 32'(ram_word), 32'd0);
    arm = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    snap();
    repeat (4) tick();
    check("t6_nowr", 32'(req_cnt - req_base), 32'd0);
    ram_lo = 0;
    ram_hi = 2;
    run_full(32'd0, 32'hFFFF_FFF8);

    // Random runs
    for (int k = 0; k < 3; k++) begin
      ram_hi = $urandom_range(0, 3);
      adc_hi = $urandom_range(0, 3);
      run_full(32'($urandom_range(0, 3)), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
